// File: rtl/addr_unit.sv
// addr_unit: address-generation stage between the LS reservation station and
// the memory side. Computes vj+a, keeps ops in program order in a small FIFO,
// and drains the head to the load buffer (loads) or the ROB (store addresses).

`ifndef NOP
`define NOP 6'd0
`endif
`ifndef LB
`define LB  6'd11
`endif
`ifndef LHU
`define LHU 6'd15
`endif
`ifndef SB
`define SB  6'd16
`endif
`ifndef SW
`define SW  6'd18
`endif

module addr_unit #(
    parameter int ID_WIDTH  = 32,
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 addrunit_rdy_out,
    input  logic [ID_WIDTH-1:0]  rs_addrunit_a_in,
    input  logic [ID_WIDTH-1:0]  rs_addrunit_vj_in,
    input  logic [ROB_WIDTH-1:0] rs_addrunit_dest_in,
    input  logic [OP_WIDTH-1:0]  rs_addrunit_opcode_in,
    input  logic                 rob_addrunit_rst_in,
    input  logic                 lbuffer_addrunit_rdy_in,
    output logic                 addrunit_lbuffer_en_out,
    output logic [ID_WIDTH-1:0]  addrunit_lbuffer_addr_out,
    output logic [ROB_WIDTH-1:0] addrunit_lbuffer_dest_out,
    output logic [OP_WIDTH-1:0]  addrunit_lbuffer_op_out,
    output logic                 addrunit_rob_en_out,
    output logic [ROB_WIDTH-1:0] addrunit_rob_h_out,
    output logic [ID_WIDTH-1:0]  addrunit_rob_addr_out,
    output logic [OP_WIDTH-1:0]  addrunit_rob_op_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RDY_LIM  = CNT_W'(DEPTH - 2);
    localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(`NOP);
    localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(`LB);
    localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(`LHU);
    localparam logic [OP_WIDTH-1:0] OP_SB  = OP_WIDTH'(`SB);
    localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(`SW);

    // opcode class decode
    function automatic logic is_load(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    logic [ID_WIDTH-1:0]  addr_mem_r [DEPTH];
    logic [ROB_WIDTH-1:0] dest_mem_r [DEPTH];
    logic [OP_WIDTH-1:0]  op_mem_r   [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;

    logic                 head_valid_s;
    logic                 head_load_s;
    logic                 pop_s;
    logic                 pop_load_s;
    logic                 pop_store_s;
    logic                 push_s;
    logic [CNT_W-1:0]     count_next_s;
    logic [ID_WIDTH-1:0]  eff_addr_s;

    // head pop / tail push decisions for the normal (non-frozen, non-flush) path
    always_comb begin
        head_valid_s = 1'b0;
        head_load_s  = 1'b0;
        pop_load_s   = 1'b0;
        pop_store_s  = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        count_next_s = count_r;
        eff_addr_s   = rs_addrunit_vj_in + rs_addrunit_a_in;

        head_valid_s = (count_r != {CNT_W{1'b0}});
        head_load_s  = is_load(op_mem_r[head_r]);
        if (head_valid_s) begin
            // a stalled load also blocks every store queued behind it
            if (head_load_s) begin
                pop_load_s = lbuffer_addrunit_rdy_in;
            end else begin
                pop_store_s = 1'b1;
            end
        end else begin
            pop_load_s  = 1'b0;
            pop_store_s = 1'b0;
        end
        pop_s = pop_load_s | pop_store_s;

        if (is_load(rs_addrunit_opcode_in) || is_store(rs_addrunit_opcode_in)) begin
            // full FIFO accepts only when the head leaves in the same cycle
            push_s = (count_r != FULL_CNT) || pop_s;
        end else begin
            push_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO state and registered outputs: reset, freeze, flush, then enqueue/dequeue
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ID_WIDTH{1'b0}};
                dest_mem_r[i] <= {ROB_WIDTH{1'b0}};
                op_mem_r[i]   <= OP_NOP;
            end
            head_r                    <= {PTR_W{1'b0}};
            tail_r                    <= {PTR_W{1'b0}};
            count_r                   <= {CNT_W{1'b0}};
            addrunit_rdy_out          <= 1'b1;
            addrunit_lbuffer_en_out   <= 1'b0;
            addrunit_lbuffer_addr_out <= {ID_WIDTH{1'b0}};
            addrunit_lbuffer_dest_out <= {ROB_WIDTH{1'b0}};
            addrunit_lbuffer_op_out   <= OP_NOP;
            addrunit_rob_en_out       <= 1'b0;
            addrunit_rob_h_out        <= {ROB_WIDTH{1'b0}};
            addrunit_rob_addr_out     <= {ID_WIDTH{1'b0}};
            addrunit_rob_op_out       <= OP_NOP;
        end else if (!rdy_in) begin
            addrunit_lbuffer_en_out <= 1'b0;
            addrunit_rob_en_out     <= 1'b0;
        end else if (rob_addrunit_rst_in) begin
            head_r                  <= {PTR_W{1'b0}};
            tail_r                  <= {PTR_W{1'b0}};
            count_r                 <= {CNT_W{1'b0}};
            addrunit_rdy_out        <= 1'b1;
            addrunit_lbuffer_en_out <= 1'b0;
            addrunit_rob_en_out     <= 1'b0;
        end else begin
            addrunit_lbuffer_en_out <= pop_load_s;
            addrunit_rob_en_out     <= pop_store_s;
            if (pop_load_s) begin
                addrunit_lbuffer_addr_out <= addr_mem_r[head_r];
                addrunit_lbuffer_dest_out <= dest_mem_r[head_r];
                addrunit_lbuffer_op_out   <= op_mem_r[head_r];
            end
            if (pop_store_s) begin
                addrunit_rob_addr_out <= addr_mem_r[head_r];
                addrunit_rob_h_out    <= dest_mem_r[head_r];
                addrunit_rob_op_out   <= op_mem_r[head_r];
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (push_s) begin
                addr_mem_r[tail_r] <= eff_addr_s;
                dest_mem_r[tail_r] <= rs_addrunit_dest_in;
                op_mem_r[tail_r]   <= rs_addrunit_opcode_in;
                tail_r             <= tail_r + PTR_W'(1);
            end
            count_r          <= count_next_s;
            // one slot of slack: RS may already be issuing when it sees rdy drop
            addrunit_rdy_out <= (count_next_s <= RDY_LIM);
        end
    end

endmodule

// File: tb/tb_addr_unit.sv
// Directed testbench for addr_unit: a vector table for the basic data path
// followed by hand-written multi-cycle sequences (reset, ordering, full, flush,
// freeze).

module tb_addr_unit;

    localparam logic [5:0] T_NOP = 6'd0;
    localparam logic [5:0] T_LB  = 6'd11;
    localparam logic [5:0] T_LW  = 6'd13;
    localparam logic [5:0] T_LHU = 6'd15;
    localparam logic [5:0] T_SB  = 6'd16;
    localparam logic [5:0] T_SW  = 6'd18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        au_rdy;
    logic [31:0] a_in = 32'd0;
    logic [31:0] vj_in = 32'd0;
    logic [3:0]  dest_in = 4'd0;
    logic [5:0]  op_in = 6'd0;
    logic        rob_rst = 1'b0;
    logic        lb_rdy = 1'b0;
    logic        lb_en;
    logic [31:0] lb_addr;
    logic [3:0]  lb_dest;
    logic [5:0]  lb_op;
    logic        rob_en;
    logic [3:0]  rob_h;
    logic [31:0] rob_addr;
    logic [5:0]  rob_op;

    int checks = 0;
    int errors = 0;

    addr_unit #(.ID_WIDTH(32), .ROB_WIDTH(4), .OP_WIDTH(6), .DEPTH(4)) dut (
        .clk_in                   (clk),
        .rst_in                   (rst),
        .rdy_in                   (rdy),
        .addrunit_rdy_out         (au_rdy),
        .rs_addrunit_a_in         (a_in),
        .rs_addrunit_vj_in        (vj_in),
        .rs_addrunit_dest_in      (dest_in),
        .rs_addrunit_opcode_in    (op_in),
        .rob_addrunit_rst_in      (rob_rst),
        .lbuffer_addrunit_rdy_in  (lb_rdy),
        .addrunit_lbuffer_en_out  (lb_en),
        .addrunit_lbuffer_addr_out(lb_addr),
        .addrunit_lbuffer_dest_out(lb_dest),
        .addrunit_lbuffer_op_out  (lb_op),
        .addrunit_rob_en_out      (rob_en),
        .addrunit_rob_h_out       (rob_h),
        .addrunit_rob_addr_out    (rob_addr),
        .addrunit_rob_op_out      (rob_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] a;
        logic [3:0]  dest;
        logic        lrdy;
        logic        x_lb_en;
        logic [31:0] x_lb_addr;
        logic [3:0]  x_lb_dest;
        logic [5:0]  x_lb_op;
        logic        x_rob_en;
        logic [31:0] x_rob_addr;
        logic [3:0]  x_rob_h;
        logic [5:0]  x_rob_op;
        logic        x_rdy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] vj,
                         input logic [31:0] a, input logic [3:0] dest);
        op_in   = op;
        vj_in   = vj;
        a_in    = a;
        dest_in = dest;
    endtask

    initial begin
        // cycle-by-cycle table starting from an empty FIFO
        vecs[0] = '{T_LW,  32'h0000_1000, 32'hFFFF_FFFC, 4'd3, 1'b1,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[1] = '{T_NOP, 32'h0, 32'h0, 4'd0, 1'b1,
                    1'b1, 32'h0000_0FFC, 4'd3, T_LW, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[2] = '{T_SW,  32'h0000_0020, 32'h0000_0004, 4'd5, 1'b0,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[3] = '{T_LB,  32'h0000_0100, 32'h0000_0001, 4'd6, 1'b0,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b1, 32'h0000_0024, 4'd5, T_SW, 1'b1};
        vecs[4] = '{T_SB,  32'hFFFF_FFFF, 32'h0000_0002, 4'd7, 1'b0,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[5] = '{T_NOP, 32'h0, 32'h0, 4'd0, 1'b1,
                    1'b1, 32'h0000_0101, 4'd6, T_LB, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[6] = '{T_NOP, 32'h0, 32'h0, 4'd0, 1'b0,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b1, 32'h0000_0001, 4'd7, T_SB, 1'b1};
        vecs[7] = '{T_LHU, 32'h7FFF_FFFF, 32'h0000_0001, 4'd9, 1'b1,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[8] = '{6'd40, 32'h0000_5555, 32'h0000_0001, 4'd10, 1'b1,
                    1'b1, 32'h8000_0000, 4'd9, T_LHU, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};
        vecs[9] = '{T_NOP, 32'h0, 32'h0, 4'd0, 1'b1,
                    1'b0, 32'h0, 4'd0, T_NOP, 1'b0, 32'h0, 4'd0, T_NOP, 1'b1};

        // reset held for two cycles
        drive(T_NOP, 32'h0, 32'h0, 4'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_lb_en", {31'd0, lb_en}, 32'd0);
        chk("rst_rob_en", {31'd0, rob_en}, 32'd0);
        chk("rst_rdy", {31'd0, au_rdy}, 32'd1);
        chk("rst_lb_op", {26'd0, lb_op}, {26'd0, T_NOP});
        chk("rst_rob_op", {26'd0, rob_op}, {26'd0, T_NOP});
        chk("rst_lb_addr", lb_addr, 32'd0);

        // table-driven data path
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].vj, vecs[i].a, vecs[i].dest);
            lb_rdy = vecs[i].lrdy;
            tick();
            chk($sformatf("vec%0d_lb_en", i), {31'd0, lb_en}, {31'd0, vecs[i].x_lb_en});
            chk($sformatf("vec%0d_rob_en", i), {31'd0, rob_en}, {31'd0, vecs[i].x_rob_en});
            chk($sformatf("vec%0d_rdy", i), {31'd0, au_rdy}, {31'd0, vecs[i].x_rdy});
            if (vecs[i].x_lb_en) begin
                chk($sformatf("vec%0d_lb_addr", i), lb_addr, vecs[i].x_lb_addr);
                chk($sformatf("vec%0d_lb_dest", i), {28'd0, lb_dest}, {28'd0, vecs[i].x_lb_dest});
                chk($sformatf("vec%0d_lb_op", i), {26'd0, lb_op}, {26'd0, vecs[i].x_lb_op});
            end
            if (vecs[i].x_rob_en) begin
                chk($sformatf("vec%0d_rob_addr", i), rob_addr, vecs[i].x_rob_addr);
                chk($sformatf("vec%0d_rob_h", i), {28'd0, rob_h}, {28'd0, vecs[i].x_rob_h});
                chk($sformatf("vec%0d_rob_op", i), {26'd0, rob_op}, {26'd0, vecs[i].x_rob_op});
            end
        end

        // ordering: a stalled load holds back the store queued behind it
        lb_rdy = 1'b0;
        drive(T_LW, 32'h0000_0200, 32'h0000_0008, 4'd1);
        tick();
        drive(T_SW, 32'h0000_0300, 32'h0000_0010, 4'd2);
        tick();
        drive(T_NOP, 32'h0, 32'h0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ord_stall%0d_lb", i), {31'd0, lb_en}, 32'd0);
            chk($sformatf("ord_stall%0d_rob", i), {31'd0, rob_en}, 32'd0);
        end
        lb_rdy = 1'b1;
        tick();
        chk("ord_load_en", {31'd0, lb_en}, 32'd1);
        chk("ord_load_dest", {28'd0, lb_dest}, 32'd1);
        chk("ord_load_addr", lb_addr, 32'h0000_0208);
        chk("ord_load_rob_en", {31'd0, rob_en}, 32'd0);
        tick();
        chk("ord_store_en", {31'd0, rob_en}, 32'd1);
        chk("ord_store_h", {28'd0, rob_h}, 32'd2);
        chk("ord_store_addr", rob_addr, 32'h0000_0310);
        chk("ord_store_lb_en", {31'd0, lb_en}, 32'd0);

        // fill to DEPTH, then push and pop together while full
        lb_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(T_LW, 32'h0000_1000, 32'(i * 4), 4'(i + 1));
            tick();
            chk($sformatf("full_fill%0d_rdy", i), {31'd0, au_rdy}, (i >= 2) ? 32'd0 : 32'd1);
            chk($sformatf("full_fill%0d_lb", i), {31'd0, lb_en}, 32'd0);
        end
        lb_rdy = 1'b1;
        drive(T_LW, 32'h0000_1000, 32'h0000_0010, 4'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(T_NOP, 32'h0, 32'h0, 4'd0);
            chk($sformatf("full_drain%0d_en", i), {31'd0, lb_en}, 32'd1);
            chk($sformatf("full_drain%0d_dest", i), {28'd0, lb_dest}, 32'(i + 1));
            chk($sformatf("full_drain%0d_addr", i), lb_addr, 32'h0000_1000 + 32'(i * 4));
            chk($sformatf("full_drain%0d_rdy", i), {31'd0, au_rdy}, (i <= 1) ? 32'd0 : 32'd1);
        end
        tick();
        chk("full_empty_en", {31'd0, lb_en}, 32'd0);

        // flush discards queued ops and the op presented alongside it
        lb_rdy = 1'b0;
        drive(T_LW, 32'h0000_0040, 32'h0, 4'd1);
        tick();
        drive(T_LB, 32'h0000_0050, 32'h0, 4'd2);
        tick();
        drive(T_LW, 32'h0000_0060, 32'h0, 4'd3);
        rob_rst = 1'b1;
        lb_rdy  = 1'b1;
        tick();
        rob_rst = 1'b0;
        drive(T_NOP, 32'h0, 32'h0, 4'd0);
        chk("flush_lb_en", {31'd0, lb_en}, 32'd0);
        chk("flush_rdy", {31'd0, au_rdy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_after%0d_lb", i), {31'd0, lb_en}, 32'd0);
            chk($sformatf("flush_after%0d_rob", i), {31'd0, rob_en}, 32'd0);
        end

        // freeze with a queued store; inputs during freeze are ignored
        lb_rdy = 1'b0;
        drive(T_SW, 32'h0000_0040, 32'h0, 4'd4);
        tick();
        rdy = 1'b0;
        drive(T_LW, 32'h0000_0070, 32'h0, 4'd8);
        lb_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("frz%0d_rob", i), {31'd0, rob_en}, 32'd0);
            chk($sformatf("frz%0d_lb", i), {31'd0, lb_en}, 32'd0);
        end
        rdy = 1'b1;
        drive(T_NOP, 32'h0, 32'h0, 4'd0);
        tick();
        chk("frz_store_en", {31'd0, rob_en}, 32'd1);
        chk("frz_store_h", {28'd0, rob_h}, 32'd4);
        chk("frz_store_addr", rob_addr, 32'h0000_0040);
        tick();
        chk("frz_after_rob", {31'd0, rob_en}, 32'd0);
        chk("frz_after_lb", {31'd0, lb_en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
